// File: rtl/pipe_perf_monitor_if.sv
// Bundle of control, event and readback signals between the performance
// monitor (slave) and whoever drives it: the CPU wrapper or a bench (master).
interface pipe_perf_monitor_if #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int LIM_W   = 16,
  parameter int SEL_W   = $clog2(NUM_EVT + 1)
);
  logic               start_i;
  logic               clear_i;
  logic [LIM_W-1:0]   limit_i;
  logic [NUM_EVT-1:0] evt_i;
  logic [SEL_W-1:0]   rd_sel_i;
  logic [CNT_W-1:0]   rd_data_o;
  logic [NUM_EVT:0]   ovf_o;
  logic               running_o;
  logic               done_o;

  modport master (
    output start_i, clear_i, limit_i, evt_i, rd_sel_i,
    input  rd_data_o, ovf_o, running_o, done_o
  );

  modport slave (
    input  start_i, clear_i, limit_i, evt_i, rd_sel_i,
    output rd_data_o, ovf_o, running_o, done_o
  );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Performance monitor for the pipelined CPU: a saturating cycle counter plus
// NUM_EVT saturating event counters, gated by a bounded run window.
// Counters are read back through a registered select port.
// Optional build macro PERF_SNAPSHOT_EN adds snap_i and a shadow copy of all
// counters; readback then comes from the shadows instead of the live counters.
//
// state  | meaning
// IDLE   | not counting; waiting for start_i
// RUN    | counting cycles and events every clock
// DONE   | run limit reached; counters frozen, start_i resumes RUN
module pipe_perf_monitor #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int LIM_W   = 16
) (
  input logic clk_i,
  input logic rst_i,
`ifdef PERF_SNAPSHOT_EN
  input logic snap_i,
`endif
  pipe_perf_monitor_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_EVT + 1);
  localparam int CMP_W = (CNT_W > LIM_W) ? CNT_W : LIM_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] evt_cnt_q [NUM_EVT];
  logic [CNT_W-1:0] evt_cnt_d [NUM_EVT];
  logic [NUM_EVT:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             running_q, done_q;
  logic             limit_hit;
  logic [CNT_W-1:0] src_cyc;
  logic [CNT_W-1:0] src_evt [NUM_EVT];

  // Limit reached when the cycle about to be counted is the last one; a
  // saturated cycle counter always counts as reached so the run still ends.
  always_comb begin
    limit_hit = 1'b0;
    if (bus.limit_i != '0) begin
      limit_hit = (&cyc_q) ||
                  (CMP_W'(cyc_q) >= (CMP_W'(bus.limit_i) - CMP_W'(1)));
    end
  end

  // Next-state logic; clear_i overrides any start request.
  always_comb begin
    state_d = state_q;
    if (bus.clear_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.start_i) state_d = S_RUN;
        S_RUN:   if (limit_hit) state_d = S_DONE;
        S_DONE:  if (bus.start_i) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Saturating counters; ovf bit set when an increment is blocked at all-ones.
  always_comb begin
    cyc_d = cyc_q;
    ovf_d = ovf_q;
    for (int k = 0; k < NUM_EVT; k++) evt_cnt_d[k] = evt_cnt_q[k];
    if (bus.clear_i) begin
      cyc_d = '0;
      ovf_d = '0;
      for (int k = 0; k < NUM_EVT; k++) evt_cnt_d[k] = '0;
    end else if (state_q == S_RUN) begin
      if (&cyc_q) ovf_d[NUM_EVT] = 1'b1;
      else        cyc_d = cyc_q + CNT_W'(1);
      for (int k = 0; k < NUM_EVT; k++) begin
        if (bus.evt_i[k]) begin
          if (&evt_cnt_q[k]) ovf_d[k] = 1'b1;
          else               evt_cnt_d[k] = evt_cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shd_cyc_q, shd_cyc_d;
  logic [CNT_W-1:0] shd_evt_q [NUM_EVT];
  logic [CNT_W-1:0] shd_evt_d [NUM_EVT];

  // Shadow load: final values on RUN->DONE win over a same-cycle snap_i,
  // which captures the pre-increment values.
  always_comb begin
    shd_cyc_d = shd_cyc_q;
    for (int k = 0; k < NUM_EVT; k++) shd_evt_d[k] = shd_evt_q[k];
    if (bus.clear_i) begin
      shd_cyc_d = '0;
      for (int k = 0; k < NUM_EVT; k++) shd_evt_d[k] = '0;
    end else if (state_q == S_RUN && state_d == S_DONE) begin
      shd_cyc_d = cyc_d;
      for (int k = 0; k < NUM_EVT; k++) shd_evt_d[k] = evt_cnt_d[k];
    end else if (snap_i) begin
      shd_cyc_d = cyc_q;
      for (int k = 0; k < NUM_EVT; k++) shd_evt_d[k] = evt_cnt_q[k];
    end
  end

  // Shadow registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shd_cyc_q <= '0;
      for (int k = 0; k < NUM_EVT; k++) shd_evt_q[k] <= '0;
    end else begin
      shd_cyc_q <= shd_cyc_d;
      for (int k = 0; k < NUM_EVT; k++) shd_evt_q[k] <= shd_evt_d[k];
    end
  end

  // Readback sources are the shadows.
  always_comb begin
    src_cyc = shd_cyc_q;
    for (int k = 0; k < NUM_EVT; k++) src_evt[k] = shd_evt_q[k];
  end
`else
  // Readback sources are the live counters.
  always_comb begin
    src_cyc = cyc_q;
    for (int k = 0; k < NUM_EVT; k++) src_evt[k] = evt_cnt_q[k];
  end
`endif

  // Read mux; unused select codes read zero.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (bus.rd_sel_i == SEL_W'(k)) rd_data_d = src_evt[k];
    end
    if (bus.rd_sel_i == SEL_W'(NUM_EVT)) rd_data_d = src_cyc;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      ovf_q     <= '0;
      rd_data_q <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < NUM_EVT; k++) evt_cnt_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
      for (int k = 0; k < NUM_EVT; k++) evt_cnt_q[k] <= evt_cnt_d[k];
    end
  end

  assign bus.rd_data_o = rd_data_q;
  assign bus.ovf_o     = ovf_q;
  assign bus.running_o = running_q;
  assign bus.done_o    = done_q;
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: a full-width instance plus a 4-bit counter
// instance for saturation. Read expectations go through a scoreboard queue.
module tb_pipe_perf_monitor;
  localparam int NUM_EVT = 4;
  localparam int CNT_W   = 32;
  localparam int LIM_W   = 16;
  localparam int SAT_W   = 4;
  localparam int SEL_W   = $clog2(NUM_EVT + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_perf_monitor_if #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .LIM_W(LIM_W)) bus ();
  pipe_perf_monitor_if #(.NUM_EVT(NUM_EVT), .CNT_W(SAT_W), .LIM_W(LIM_W)) sbus ();

`ifdef PERF_SNAPSHOT_EN
  logic snap   = 1'b0;
  logic snap_s = 1'b0;
`endif

  pipe_perf_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .LIM_W(LIM_W)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
`ifdef PERF_SNAPSHOT_EN
    .snap_i(snap),
`endif
    .bus   (bus)
  );

  pipe_perf_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(SAT_W), .LIM_W(LIM_W)) u_sat (
    .clk_i (clk),
    .rst_i (rst),
`ifdef PERF_SNAPSHOT_EN
    .snap_i(snap_s),
`endif
    .bus   (sbus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  logic [CNT_W-1:0] sb_exp [$];
  int               sb_due [$];
  bit               sb_sat [$];
  string            sb_nm  [$];
  logic [CNT_W-1:0] sb_act;

  always @(posedge clk) cyc_cnt++;

  // Scoreboard: read data is due one edge after the select was driven.
  always @(negedge clk) begin
    while (sb_exp.size() != 0 && sb_due[0] <= cyc_cnt) begin
      sb_act = sb_sat[0] ? CNT_W'(sbus.rd_data_o) : bus.rd_data_o;
      checks++;
      if (sb_act !== sb_exp[0]) begin
        failures++;
        $display("FAIL %s: rd_data=%0d expected %0d", sb_nm[0], sb_act, sb_exp[0]);
      end
      void'(sb_exp.pop_front());
      void'(sb_due.pop_front());
      void'(sb_sat.pop_front());
      void'(sb_nm.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a read select and queue its expected value; caller supplies the edge.
  task automatic rd_push(input bit sat, input int sel, input logic [CNT_W-1:0] exp,
                         input string nm);
    if (sat) sbus.rd_sel_i = SEL_W'(sel);
    else     bus.rd_sel_i  = SEL_W'(sel);
    sb_exp.push_back(exp);
    sb_due.push_back(cyc_cnt + 1);
    sb_sat.push_back(sat);
    sb_nm.push_back(nm);
  endtask

  task automatic rd(input bit sat, input int sel, input logic [CNT_W-1:0] exp,
                    input string nm);
    rd_push(sat, sel, exp, nm);
    tick();
  endtask

  task automatic pulse_clear();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.running_o !== 1'b0 || bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: running=%b done=%b expected 0 0", bus.running_o, bus.done_o);
    end
    checks++;
    if (bus.ovf_o !== '0) begin
      failures++;
      $display("FAIL reset_ovf: ovf=%b expected 0", bus.ovf_o);
    end
    for (int s = 0; s <= NUM_EVT + 1; s++) rd(1'b0, s, '0, "reset_read");
    rd(1'b1, NUM_EVT, '0, "reset_read_sat");
  endtask

  task automatic test_run_limit();
    bus.limit_i = 16'd30;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    checks++;
    if (bus.running_o !== 1'b1 || bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL limit_enter_run: running=%b done=%b expected 1 0", bus.running_o, bus.done_o);
    end
    for (int i = 0; i < 30; i++) begin
      bus.evt_i = {2'b00, (i == 10 || i == 11), (i < 4)};
      tick();
      if (i == 28) begin
        checks++;
        if (bus.done_o !== 1'b0) begin
          failures++;
          $display("FAIL limit_early_done: done=%b expected 0", bus.done_o);
        end
      end
    end
    bus.evt_i = '0;
    checks++;
    if (bus.done_o !== 1'b1 || bus.running_o !== 1'b0) begin
      failures++;
      $display("FAIL limit_done: running=%b done=%b expected 0 1", bus.running_o, bus.done_o);
    end
    bus.evt_i = '1;
    repeat (5) tick();
    bus.evt_i = '0;
    rd(1'b0, 0, 32'd4, "limit_evt0");
    rd(1'b0, 1, 32'd2, "limit_evt1");
    rd(1'b0, 2, 32'd0, "limit_evt2");
    rd(1'b0, 4, 32'd30, "limit_cyc");
    rd(1'b0, 5, 32'd0, "limit_sel_oob");
    checks++;
    if (bus.ovf_o !== '0 || bus.done_o !== 1'b1) begin
      failures++;
      $display("FAIL limit_frozen: ovf=%b done=%b expected 0 1", bus.ovf_o, bus.done_o);
    end
  endtask

  task automatic test_restart();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    checks++;
    if (bus.running_o !== 1'b1) begin
      failures++;
      $display("FAIL restart_run: running=%b expected 1", bus.running_o);
    end
    bus.evt_i = 4'b0001;
    tick();
    bus.evt_i = '0;
    checks++;
    if (bus.done_o !== 1'b1) begin
      failures++;
      $display("FAIL restart_done: done=%b expected 1", bus.done_o);
    end
    rd(1'b0, 4, 32'd31, "restart_cyc");
    rd(1'b0, 0, 32'd5, "restart_evt0");
    pulse_clear();
    checks++;
    if (bus.running_o !== 1'b0 || bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL clear_idle: running=%b done=%b expected 0 0", bus.running_o, bus.done_o);
    end
    bus.limit_i = 16'd1;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    checks++;
    if (bus.done_o !== 1'b1) begin
      failures++;
      $display("FAIL limit1_done: done=%b expected 1", bus.done_o);
    end
    rd(1'b0, 4, 32'd1, "limit1_cyc");
  endtask

  task automatic test_unbounded_clear();
    logic [NUM_EVT-1:0] e;
    int m0;
    pulse_clear();
    bus.limit_i = '0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    m0 = 0;
    for (int i = 0; i < 100; i++) begin
      e = NUM_EVT'($urandom_range(0, 15));
      bus.evt_i = e;
`ifdef PERF_SNAPSHOT_EN
      if (i == 50) rd_push(1'b0, 4, '0, "unb_cyc_mid");
      if (i == 60) rd_push(1'b0, 0, '0, "unb_evt0_mid");
`else
      if (i == 50) rd_push(1'b0, 4, 32'd50, "unb_cyc_mid");
      if (i == 60) rd_push(1'b0, 0, CNT_W'(m0), "unb_evt0_mid");
`endif
      tick();
      m0 += int'(e[0]);
    end
    bus.evt_i = '0;
    checks++;
    if (bus.running_o !== 1'b1 || bus.done_o !== 1'b0) begin
      failures++;
      $display("FAIL unb_running: running=%b done=%b expected 1 0", bus.running_o, bus.done_o);
    end
    bus.clear_i = 1'b1;
    bus.start_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    bus.start_i = 1'b0;
    checks++;
    if (bus.running_o !== 1'b0 || bus.done_o !== 1'b0 || bus.ovf_o !== '0) begin
      failures++;
      $display("FAIL clear_prio: running=%b done=%b ovf=%b expected 0 0 0",
               bus.running_o, bus.done_o, bus.ovf_o);
    end
    for (int s = 0; s <= NUM_EVT; s++) rd(1'b0, s, '0, "clear_read");
  endtask

  task automatic test_saturation();
    sbus.limit_i = '0;
    sbus.start_i = 1'b1;
    tick();
    sbus.start_i = 1'b0;
    sbus.evt_i = 4'b0100;
    repeat (20) tick();
    sbus.evt_i = '0;
    checks++;
    if (sbus.ovf_o !== 5'b10100) begin
      failures++;
      $display("FAIL sat_ovf: ovf=%b expected 10100", sbus.ovf_o);
    end
`ifdef PERF_SNAPSHOT_EN
    snap_s = 1'b1;
    tick();
    snap_s = 1'b0;
`endif
    rd(1'b1, 2, CNT_W'(15), "sat_evt2");
    rd(1'b1, 4, CNT_W'(15), "sat_cyc");
    rd(1'b1, 0, '0, "sat_evt0");
    sbus.clear_i = 1'b1;
    tick();
    sbus.clear_i = 1'b0;
    checks++;
    if (sbus.ovf_o !== '0 || sbus.running_o !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear: ovf=%b running=%b expected 0 0", sbus.ovf_o, sbus.running_o);
    end
    rd(1'b1, 2, '0, "sat_evt2_cleared");
  endtask

  task automatic test_reset_midrun();
    pulse_clear();
    bus.limit_i = '0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.evt_i = 4'b0001;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.evt_i = '0;
    checks++;
    if (bus.running_o !== 1'b0 || bus.done_o !== 1'b0 || bus.ovf_o !== '0) begin
      failures++;
      $display("FAIL midrun_rst: running=%b done=%b ovf=%b expected 0 0 0",
               bus.running_o, bus.done_o, bus.ovf_o);
    end
    rd(1'b0, 0, '0, "midrun_rst_evt0");
    rd(1'b0, 4, '0, "midrun_rst_cyc");
  endtask

`ifdef PERF_SNAPSHOT_EN
  task automatic test_snapshot();
    pulse_clear();
    bus.limit_i = 16'd30;
    bus.evt_i = 4'b0001;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      snap = (i == 10);
      if (i == 20) rd_push(1'b0, 4, 32'd10, "snap_cyc_mid");
      if (i == 21) rd_push(1'b0, 0, 32'd10, "snap_evt0_mid");
      tick();
    end
    snap = 1'b0;
    bus.evt_i = '0;
    checks++;
    if (bus.done_o !== 1'b1) begin
      failures++;
      $display("FAIL snap_done: done=%b expected 1", bus.done_o);
    end
    rd(1'b0, 4, 32'd30, "snap_cyc_final");
    rd(1'b0, 0, 32'd30, "snap_evt0_final");
    rd(1'b0, NUM_EVT + 1, '0, "snap_sel_oob");
  endtask
`endif

  initial begin
    bus.start_i   = 1'b0;
    bus.clear_i   = 1'b0;
    bus.limit_i   = '0;
    bus.evt_i     = '0;
    bus.rd_sel_i  = '0;
    sbus.start_i  = 1'b0;
    sbus.clear_i  = 1'b0;
    sbus.limit_i  = '0;
    sbus.evt_i    = '0;
    sbus.rd_sel_i = '0;

    test_reset();
    test_run_limit();
    test_restart();
    test_unbounded_clear();
    test_saturation();
    test_reset_midrun();
`ifdef PERF_SNAPSHOT_EN
    test_snapshot();
`endif

    repeat (3) tick();
    checks++;
    if (sb_exp.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", sb_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
